// File: rtl/rns_reverse_conv_32_17_13_11.sv
// Iterative mixed-radix reverse converter for the {32,17,13,11} residue system.
// One mixed-radix digit is resolved per cycle; the weighted sum is registered before the result is held.
module rns_reverse_conv_32_17_13_11 #(
  parameter int OUT_W     = 17,
  parameter int ERR_CHECK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       r32,
  input  logic [4:0]       r17,
  input  logic [3:0]       r13,
  input  logic [3:0]       r11,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] x,
  output logic             err
);

  typedef enum logic [2:0] {IDLE, D2, D3, D4, SUM, HOLD} state_t;

  state_t state_q, state_d;

  logic [4:0]       r32_p0, r17_p0;
  logic [3:0]       r13_p0, r11_p0;
  logic             err_p0;
  logic [4:0]       a2_p1;
  logic [3:0]       a3_p2;
  logic [3:0]       a4_p3;
  logic [OUT_W-1:0] x_p4;

  function automatic logic [4:0] mod17(input logic [11:0] v);
    logic [11:0] t;
    t = v % 12'd17;
    return t[4:0];
  endfunction

  function automatic logic [3:0] mod13(input logic [11:0] v);
    logic [11:0] t;
    t = v % 12'd13;
    return t[3:0];
  endfunction

  function automatic logic [3:0] mod11(input logic [11:0] v);
    logic [11:0] t;
    t = v % 12'd11;
    return t[3:0];
  endfunction

  logic        in_err;
  logic [4:0]  d17, a2_d;
  logic [3:0]  u13, v13, w13, a3_d;
  logic [3:0]  u11, v11, t11, s11, q11, a4_d;
  logic [16:0] x_sum;

  assign in_err = (ERR_CHECK != 0) && ((r17 > 5'd16) || (r13 > 4'd12) || (r11 > 4'd10));

  // Each subtraction adds the modulus first so the unsigned intermediate never wraps.
  always_comb begin
    d17  = mod17(12'(mod17(12'(r17_p0))) + 12'd17 - 12'(mod17(12'(r32_p0))));
    a2_d = mod17(12'(d17) * 12'd8);

    u13  = mod13(12'(mod13(12'(r13_p0))) + 12'd13 - 12'(mod13(12'(r32_p0))));
    v13  = mod13(12'(u13) * 12'd11);
    w13  = mod13(12'(v13) + 12'd13 - 12'(mod13(12'(a2_p1))));
    a3_d = mod13(12'(w13) * 12'd10);

    u11  = mod11(12'(mod11(12'(r11_p0))) + 12'd11 - 12'(mod11(12'(r32_p0))));
    v11  = mod11(12'(u11) * 12'd10);
    t11  = mod11(12'(v11) + 12'd11 - 12'(mod11(12'(a2_p1))));
    s11  = mod11(12'(t11) * 12'd2);
    q11  = mod11(12'(s11) + 12'd11 - 12'(mod11(12'(a3_p2))));
    a4_d = mod11(12'(q11) * 12'd6);

    x_sum = 17'(r32_p0) + 17'(a2_p1) * 17'd32 + 17'(a3_p2) * 17'd544
          + 17'(a4_p3) * 17'd7072;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = D2;
      D2:      state_d = D3;
      D3:      state_d = D4;
      D4:      state_d = SUM;
      SUM:     state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r32_p0 <= '0;
      r17_p0 <= '0;
      r13_p0 <= '0;
      r11_p0 <= '0;
      err_p0 <= 1'b0;
      a2_p1  <= '0;
      a3_p2  <= '0;
      a4_p3  <= '0;
      x_p4   <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          r32_p0 <= r32;
          r17_p0 <= r17;
          r13_p0 <= r13;
          r11_p0 <= r11;
          err_p0 <= in_err;
        end
        D2:  a2_p1 <= a2_d;
        D3:  a3_p2 <= a3_d;
        D4:  a4_p3 <= a4_d;
        // Weighted sum stage: out-of-range residues force a zero result
        SUM: x_p4  <= err_p0 ? '0 : OUT_W'(x_sum);
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign x         = x_p4;
  assign err       = err_p0;

endmodule

// File: tb/tb_rns_reverse_conv_32_17_13_11.sv
// Scoreboard bench for the RNS reverse converter: randomized residue sets against a CRT search model.
// A second instance with range checking disabled runs in lockstep on the same inputs.
module tb_rns_reverse_conv_32_17_13_11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [4:0]  r32 = '0, r17 = '0;
  logic [3:0]  r13 = '0, r11 = '0;
  logic        in_ready, out_valid, err;
  logic [16:0] x;
  logic        in_ready2, out_valid2, err2;
  logic [16:0] x2;

  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;
  bit     bp_rand = 1'b0;

  typedef struct {
    int     xv;
    bit     ev;
    longint acc;
  } exp_t;
  exp_t exp_q[$];

  rns_reverse_conv_32_17_13_11 #(.OUT_W(17), .ERR_CHECK(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .r32(r32), .r17(r17), .r13(r13), .r11(r11),
    .out_valid(out_valid), .out_ready(out_ready), .x(x), .err(err)
  );

  rns_reverse_conv_32_17_13_11 #(.OUT_W(17), .ERR_CHECK(0)) dut_nochk (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .r32(r32), .r17(r17), .r13(r13), .r11(r11),
    .out_valid(out_valid2), .out_ready(out_ready), .x(x2), .err(err2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: legal residues identify the unique X in [0, 77792) by direct search.
  function automatic void ref_conv(input int a, input int b, input int c, input int d,
                                   output int xr, output bit er);
    er = (b > 16) || (c > 12) || (d > 10);
    xr = 0;
    if (!er)
      for (int k = a; k < 77792; k += 32)
        if ((k % 17 == b) && (k % 13 == c) && (k % 11 == d)) xr = k;
  endfunction

  task automatic send(input int a, input int b, input int c, input int d,
                      input int xv, input bit ev);
    int   n;
    exp_t e;
    @(negedge clk);
    r32 = 5'(a); r17 = 5'(b); r13 = 4'(c); r11 = 4'(d);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    else begin
      e.xv = xv; e.ev = ev; e.acc = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    r32 = 5'($urandom); r17 = 5'($urandom); r13 = 4'($urandom); r11 = 4'($urandom);
  endtask

  task automatic send_ref(input int a, input int b, input int c, input int d);
    int xv;
    bit ev;
    ref_conv(a, b, c, d, xv, ev);
    send(a, b, c, d, xv, ev);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops one expectation per presented result and checks stability while held.
  initial begin
    bit   seen;
    int   hx;
    bit   he;
    exp_t e;
    seen = 1'b0;
    hx = 0;
    he = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) seen = 1'b0;
      else if (out_valid) begin
        chk("in_ready_in_hold", in_ready, 0);
        if (!seen) begin
          seen = 1'b1;
          hx = int'(x);
          he = err;
          if (exp_q.size() == 0) chk("spurious_result", exp_q.size(), 1);
          else begin
            e = exp_q.pop_front();
            chk("x", x, e.xv);
            chk("err", err, e.ev);
            chk("latency", cyc - e.acc, 4);
          end
        end else begin
          chk("x_hold", x, hx);
          chk("err_hold", err, he);
        end
      end else seen = 1'b0;
      if (!rst) begin
        chk("nochk_valid", out_valid2, out_valid);
        if (out_valid2) begin
          chk("nochk_err", err2, 0);
          if (!err) chk("nochk_x", x2, x);
        end
      end
    end
  end

  initial begin
    int xv;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_x", x, 0);
    chk("rst_err", err, 0);
    chk("rst_nochk_err", err2, 0);
    rst = 1'b0;

    send_ref(0, 0, 0, 0);
    for (int k = 0; k <= 4; k++) begin
      chk("busy_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    chk("idle_in_ready", in_ready, 1);
    drain();

    send_ref(31, 16, 12, 10);
    send_ref(25, 3, 8, 3);
    send_ref(31, 0, 2, 8);
    send(31, 16, 12, 10, 77791, 1'b0);
    send(25, 3, 8, 3, 12345, 1'b0);
    send(31, 0, 2, 8, 65535, 1'b0);
    send_ref(0, 17, 0, 0);
    send(0, 17, 0, 0, 0, 1'b1);
    drain();

    // Backpressure: result must hold, and a waiting request enters only after IDLE returns.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(8, 14, 12, 10, 1000, 1'b0);
    fork
      begin : second_req
        send(25, 3, 8, 3, 12345, 1'b0);
      end
      begin : release_hold
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
          @(posedge clk); #1;
          n++;
        end
        chk("hold_seen", out_valid, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("held_valid", out_valid, 1);
        chk("held_x", x, 1000);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_valid", out_valid, 0);
      end
    join
    drain();

    // Abort a conversion with reset while it sits in D3.
    send(25, 3, 8, 3, 12345, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    void'(exp_q.pop_back());
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_no_result", out_valid, 0);
    send(25, 3, 8, 3, 12345, 1'b0);
    drain();

    bp_rand = 1'b1;
    for (int i = 0; i < 250; i++) begin
      xv = $urandom_range(0, 77791);
      send(xv % 32, xv % 17, xv % 13, xv % 11, xv, 1'b0);
    end
    for (int i = 0; i < 20; i++) begin
      int b, c, d;
      b = $urandom_range(0, 16);
      c = $urandom_range(0, 12);
      d = $urandom_range(0, 10);
      case (i % 3)
        0: b = $urandom_range(17, 31);
        1: c = $urandom_range(13, 15);
        default: d = $urandom_range(11, 15);
      endcase
      send_ref($urandom_range(0, 31), b, c, d);
    end
    bp_rand = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rns_reverse_conv_32_17_13_11.md
Name: rns_reverse_conv_32_17_13_11

Overview:
- Iterative reverse converter that rebuilds a binary integer from its residues in the {32,17,13,11} moduli set, using mixed-radix conversion (MRC).
- Sits at the output of the half-period RNS datapath, after the forward reducers and the residue-channel arithmetic. It is the inverse of the forward binary-to-residue conversion.
- Dynamic range M = 77792; output 0..77791.
- Valid/ready handshake on both sides; one conversion in flight.

Parameters:
- OUT_W, 17, width of the binary result. Must be >= 17; upper bits are zero-extended.
- ERR_CHECK, 1, 1 = range-check residues and assert err; 0 = no check (err tied 0).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  residue set valid.
- in_ready  out  1  converter can accept a residue set.
- r32  in  5  residue mod 32.
- r17  in  5  residue mod 17, legal 0..16.
- r13  in  4  residue mod 13, legal 0..12.
- r11  in  4  residue mod 11, legal 0..10.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- x  out  OUT_W  reconstructed binary value.
- err  out  1  an input residue was out of range; qualified by out_valid.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, in_ready=1, out_valid=0, x=0, err=0, all digit registers=0. Reset mid-conversion aborts it; no output is produced.
- FSM: IDLE -> D2 -> D3 -> D4 -> SUM -> HOLD -> IDLE.
- in_ready=1 only in IDLE. out_valid=1 only in HOLD.
- IDLE: on in_valid&in_ready, latch r32..r11 and set err (if ERR_CHECK) = (r17>16)|(r13>12)|(r11>10). Next state D2.
- D2: a1=r32; a2=((r17-(a1 mod 17)) mod 17)*8 mod 17. Register a2. Next state D3.
- D3: a3=((((r13-a1 mod 13) mod 13)*11 - a2) mod 13)*10 mod 13. Register a3. Next state D4.
- D4: t=(((r11-a1 mod 11) mod 11)*10 - a2) mod 11; t=(t*2 - a3) mod 11; a4=t*6 mod 11. Register a4. Next state SUM.
- SUM: x = a1 + 32*a2 + 544*a3 + 7072*a4, with 17-bit exact arithmetic and no overflow (max 77791). If err=1, x=0. Next state HOLD.
- HOLD: x and err held stable while out_valid=1 and out_ready=0. On out_ready=1, next state IDLE and out_valid drops at that edge.
- Latency: acceptance edge E0; out_valid=1 after edge E4, i.e. 4 cycles. Throughput is at most 1 result per 6 cycles.
- No accept in HOLD, even if out_ready=1 in the same cycle. Accept resumes the cycle after return to IDLE.
- Modular subtraction: add the modulus before subtracting, so intermediates are never negative. Operands are pre-reduced mod m. Constant multiplies are reduced mod m in the same cycle.
- Input values change while busy: ignored; the latched copy is used.
- Constants (modular inverses): 32^-1 mod 17=8, mod 13=11, mod 11=10; 17^-1 mod 13=10, mod 11=2; 13^-1 mod 11=6.

Test Plan:
- Reset, then residues (0,0,0,0) with in_valid=1 -> in_ready=0 for E1..E5; out_valid=1 after E4; x=0, err=0.
- (31,16,12,10) -> x=77791 (maximum of range); (25,3,8,3) -> x=12345; (31,0,2,8) -> x=65535.
- (8,14,12,10) with out_ready=0 for 5 cycles -> x=1000 held stable with out_valid=1; released one edge after out_ready=1. A second in_valid presented during HOLD is accepted only after the return to IDLE.
- (0,17,0,0) -> err=1, x=0, out_valid after E4. With ERR_CHECK=0 -> err=0.
- Assert rst during D3 -> next cycle in IDLE, in_ready=1, out_valid=0, no spurious result. A subsequent (25,3,8,3) yields 12345.
- Random sweep of all X in 0..77791 (residues from the forward model) -> x==X, err=0, latency exactly 4.
